mul_req_scheduler: RTL and testbench
====================================

Name: mul_req_scheduler

Overview:
- Shares one repeated-addition multiplier datapath (registers A, B, P; B decrementer; zero detect on B) among NREQ requesters.
- Picks a requester round-robin, drives the datapath's shared operand bus and its ld_a/ld_b/ld_p/dec/clr strobes, and watches eqz.
- Returns the product to the granted requester with a one-cycle done pulse.
- Sits between client blocks and the multiplier datapath. It replaces direct single-client sequencing of the datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester job request; level, held until that requester's done.
- op_a  in  NREQ*W  packed multiplicands; slice i belongs to requester i.
- op_b  in  NREQ*W  packed multipliers (repeat counts); slice i belongs to requester i.
- gnt  out  NREQ  one-hot grant, held from LOAD_A through DONE.
- done  out  NREQ  one-cycle pulse to the granted requester when result is valid.
- result  out  2*W  product, registered, valid while result_valid=1.
- result_valid  out  1  one-cycle pulse, coincident with done.
- busy  out  1  high whenever state != IDLE.
- dp_bus  out  W  operand bus to datapath; 0 outside LOAD_A/LOAD_B.
- ld_a, ld_b, ld_p, dec, clr  out  1 each  datapath strobes.
- eqz  in  1  datapath: B register == 0.
- p_in  in  2*W  datapath P register.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - State goes to IDLE and rr pointer to 0.
  - gnt, done, result, result_valid, busy, dp_bus and all strobes go to 0.
  - Reset overrides everything, including mid-operation; the in-flight job is dropped with no done pulse.
- States are IDLE, LOAD_A, LOAD_B, ACC, DONE.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from ptr, wrapping modulo NREQ.
  - The winner's index is latched into id, gnt[id] is set, and the state goes to LOAD_A.
  - With no req set, stay in IDLE.
- LOAD_A: dp_bus=op_a[id], ld_a=1 -> LOAD_B.
- LOAD_B: dp_bus=op_b[id], ld_b=1, clr=1 (P cleared) -> ACC.
- ACC:
  - If eqz=1, assert no strobes and go to DONE.
  - Otherwise assert ld_p=1 and dec=1 (P+=A, B-=1) and stay in ACC.
- DONE:
  - result<=p_in, captured on entry so it is valid during DONE.
  - result_valid=1 and done[id]=1 for exactly one cycle.
  - gnt cleared on exit; ptr<=(id+1) mod NREQ; -> IDLE.
- Strobes, dp_bus, gnt and done are decoded from the registered state and id only (Moore). No strobe depends combinationally on req.
- Latency:
  - req sampled in IDLE at edge t gives result_valid high in cycle t+4+b, where b=op_b[id].
  - ld_p/dec pulse exactly b times.
  - A new grant is possible at the edge ending DONE+1; back-to-back jobs have one IDLE cycle between them.
- Operands are sampled only in LOAD_A/LOAD_B. Changing op_a/op_b after LOAD_B does not affect the job.
- Deasserting req[id] mid-job does not abort it: the job completes and done still pulses.
- b=0: ACC sees eqz=1 immediately, giving zero ld_p pulses, result 0 and latency 4.
- Arithmetic: the product fits 2*W with no overflow; the scheduler does no arithmetic beyond the ptr increment with wrap.
- Fairness: with all req held, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 jobs.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, LOAD_A=1, LOAD_B=2, ACC=3, DONE=4, 3-bit);
  - default W/NREQ;
  - a clog2-based index-width constant.
- One sub-module, rr_arbiter:
  - combinational first-set search from ptr over req, returning a one-hot grant, an index and an any-request flag;
  - the pointer register stays in mul_req_scheduler.
- The FSM, operand mux and result register stay in the top.

Test Plan:
- Single request: req=0001, A=3, B=4 -> LOAD_A/LOAD_B seen; 4 ld_p/dec pulses; result=12; result_valid and done[0] 8 cycles after req sampled; busy low after.
- Zero multiplier: req[2], A=200, B=0 -> no ld_p pulses; result=0 at latency 4; done[2] pulses once.
- Maximum operands, W=8: A=255, B=255 -> result=65025, 255 ld_p pulses, latency 259.
- Fairness: all four req held, each B=1 -> grant order 0,1,2,3,0,1; no done to a non-granted requester; one IDLE cycle between jobs.
- Request withdrawal: req[1] dropped during ACC (A=5, B=3) -> job completes, result=15, done[1] pulses; ptr advances to 2.
- Reset mid-ACC: rst=1 for one cycle during ACC -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent req[3] with A=2, B=2 is granted first (ptr=0 search) and yields 4.

Source files
------------

// File: rtl/mul_req_scheduler_pkg.sv
// Shared definitions for the multiplier request scheduler.
// Holds the FSM state encoding, default widths and the index-width helper.
package mul_req_scheduler_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_ACC    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_A = ST_LOAD_A,
    S_LOAD_B = ST_LOAD_B,
    S_ACC    = ST_ACC,
    S_DONE   = ST_DONE
  } state_e;

  // Index width for n requesters; never below one bit so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IW_DEF = idx_width(NREQ_DEF);

endpackage

// File: rtl/mul_req_scheduler_if.sv
// Client and datapath signal bundle for mul_req_scheduler.
//   req/op_a/op_b        : client job requests and packed operands
//   gnt/done             : one-hot grant and completion pulse per client
//   result/result_valid  : product and its one-cycle valid pulse
//   dp_bus + strobes     : operand bus and ld_a/ld_b/ld_p/dec/clr to datapath
//   eqz/p_in             : datapath B==0 flag and P register
// slave is the scheduler side, master is the client/datapath side.
interface mul_req_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    result;
  logic              result_valid;
  logic [W-1:0]      dp_bus;
  logic              ld_a;
  logic              ld_b;
  logic              ld_p;
  logic              dec;
  logic              clr;
  logic              eqz;
  logic [2*W-1:0]    p_in;

  modport slave (
    input  req, op_a, op_b, eqz, p_in,
    output gnt, done, result, result_valid, dp_bus, ld_a, ld_b, ld_p, dec, clr
  );

  modport master (
    output req, op_a, op_b, eqz, p_in,
    input  gnt, done, result, result_valid, dp_bus, ld_a, ld_b, ld_p, dec, clr
  );
endinterface

// File: rtl/mul_req_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping modulo NREQ.
//   req : request vector      ptr : search start index
//   gnt : one-hot winner      idx : winner index      any : any request set
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int  pos_s;
  logic hit_s;

  // Walk NREQ positions starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos_s = 0;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s      = int'(ptr) + k;
      pos_s      = (pos_s >= NREQ) ? pos_s - NREQ : pos_s;
      hit_s      = req[pos_s] & ~any;
      gnt[pos_s] = hit_s;
      idx        = hit_s ? IW'(pos_s) : idx;
      any        = any | req[pos_s];
    end
  end

endmodule

// File: rtl/mul_req_scheduler.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath
// among NREQ clients. Sequences LOAD_A, LOAD_B (clearing P), ACC until the
// datapath reports B==0, then returns P to the granted client with a
// one-cycle done/result_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : client and datapath signals (slave side)
//   busy     : high whenever the FSM is not idle
module mul_req_scheduler
  import mul_req_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_req_scheduler_if.slave   bus,
  output logic                 busy
);

  localparam int IW = idx_width(NREQ);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [IW-1:0]   id_r;
  logic [IW-1:0]   ptr_r;
  logic [NREQ-1:0] gnt_r;
  logic [2*W-1:0]  result_r;

  logic [NREQ-1:0] win_gnt_s;
  logic [IW-1:0]   win_idx_s;
  logic            any_req_s;

  logic [W-1:0]    dp_bus_s;
  logic            ld_a_s;
  logic            ld_b_s;
  logic            ld_p_s;
  logic            dec_s;
  logic            clr_s;
  logic [NREQ-1:0] done_s;
  logic            result_valid_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req (bus.req),
    .ptr (ptr_r),
    .gnt (win_gnt_s),
    .idx (win_idx_s),
    .any (any_req_s)
  );

  // State, grant, winner index, rotation pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      id_r     <= '0;
      ptr_r    <= '0;
      gnt_r    <= '0;
      result_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            id_r  <= win_idx_s;
            gnt_r <= win_gnt_s;
          end
        end
        // Capture P on the edge into DONE so result is valid during DONE.
        S_ACC: begin
          if (bus.eqz) begin
            result_r <= bus.p_in;
          end
        end
        S_DONE: begin
          gnt_r <= '0;
          ptr_r <= (id_r == IW'(NREQ - 1)) ? '0 : id_r + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = any_req_s ? S_LOAD_A : S_IDLE;
      S_LOAD_A: state_nxt_s = S_LOAD_B;
      S_LOAD_B: state_nxt_s = S_ACC;
      S_ACC:    state_nxt_s = bus.eqz ? S_DONE : S_ACC;
      S_DONE:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Moore decode of datapath strobes, operand mux and completion pulse.
  // ld_p/dec additionally follow eqz so ACC stops adding once B reaches 0.
  always_comb begin
    dp_bus_s       = '0;
    ld_a_s         = 1'b0;
    ld_b_s         = 1'b0;
    ld_p_s         = 1'b0;
    dec_s          = 1'b0;
    clr_s          = 1'b0;
    done_s         = '0;
    result_valid_s = 1'b0;
    case (state_r)
      S_LOAD_A: begin
        dp_bus_s = bus.op_a[int'(id_r)*W +: W];
        ld_a_s   = 1'b1;
      end
      S_LOAD_B: begin
        dp_bus_s = bus.op_b[int'(id_r)*W +: W];
        ld_b_s   = 1'b1;
        clr_s    = 1'b1;
      end
      S_ACC: begin
        ld_p_s = ~bus.eqz;
        dec_s  = ~bus.eqz;
      end
      S_DONE: begin
        done_s         = gnt_r;
        result_valid_s = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.dp_bus       = dp_bus_s;
  assign bus.ld_a         = ld_a_s;
  assign bus.ld_b         = ld_b_s;
  assign bus.ld_p         = ld_p_s;
  assign bus.dec          = dec_s;
  assign bus.clr          = clr_s;
  assign bus.done         = done_s;
  assign bus.result_valid = result_valid_s;
  assign bus.gnt          = gnt_r;
  assign bus.result       = result_r;
  assign busy             = (state_r != S_IDLE);

endmodule

// File: tb/tb_mul_req_scheduler.sv
// Directed bench for mul_req_scheduler with a behavioural multiplier datapath.
module tb_mul_req_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_req_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  mul_req_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Datapath model: A, B, P registers, B decrementer, zero detect.
  logic [W-1:0]   a_q = '0;
  logic [W-1:0]   b_q = '0;
  logic [2*W-1:0] p_q = '0;

  always @(posedge clk) begin
    if (bus.ld_a) a_q <= bus.dp_bus;
    if (bus.ld_b) b_q <= bus.dp_bus;
    else if (bus.dec) b_q <= b_q - 8'd1;
    if (bus.clr) p_q <= '0;
    else if (bus.ld_p) p_q <= p_q + {8'd0, a_q};
  end

  assign bus.eqz  = (b_q == '0);
  assign bus.p_in = p_q;

  // Event counters sampled mid-cycle.
  int lda_n = 0, ldb_n = 0, ldp_n = 0, dec_n = 0, done_n = 0, bad_n = 0;

  always @(negedge clk) begin
    lda_n  = lda_n + int'(bus.ld_a);
    ldb_n  = ldb_n + int'(bus.ld_b);
    ldp_n  = ldp_n + int'(bus.ld_p);
    dec_n  = dec_n + int'(bus.dec);
    done_n = done_n + int'(|bus.done);
    if ((|bus.done) && ((bus.done !== bus.gnt) || !bus.result_valid)) bad_n = bad_n + 1;
    if (!bus.ld_a && !bus.ld_b && (bus.dp_bus != '0)) bad_n = bad_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_a[i*W +: W] = a;
    bus.op_b[i*W +: W] = b;
  endtask

  // Count edges until result_valid is seen; expiry is reported as a failure.
  task automatic wait_rv(input string tag, input int max, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      n++;
      if (bus.result_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    int n2;
    int b_ldp, b_dec, b_lda, b_ldb, b_done;
    int exp_ord [6];
    exp_ord = '{0, 1, 2, 3, 0, 1};

    rst      = 1'b1;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_strobes", 32'({bus.ld_a, bus.ld_b, bus.ld_p, bus.dec, bus.clr}), 32'd0);
    chk("rst_dp_bus", 32'(bus.dp_bus), 32'd0);
    rst = 1'b0;
    tick();

    // Single request: 3*4.
    set_op(0, 8'd3, 8'd4);
    b_ldp = ldp_n; b_dec = dec_n; b_lda = lda_n; b_ldb = ldb_n;
    bus.req = 4'b0001;
    wait_rv("single", 20, n);
    chk("single_latency", 32'(n), 32'd8);
    chk("single_result", 32'(bus.result), 32'd12);
    chk("single_done", 32'(bus.done), 32'b0001);
    chk("single_gnt", 32'(bus.gnt), 32'b0001);
    chk("single_ldp", 32'(ldp_n - b_ldp), 32'd4);
    chk("single_dec", 32'(dec_n - b_dec), 32'd4);
    chk("single_lda", 32'(lda_n - b_lda), 32'd1);
    chk("single_ldb", 32'(ldb_n - b_ldb), 32'd1);
    bus.req = 4'b0000;
    tick();
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_done_after", 32'(bus.done), 32'd0);
    chk("single_rv_after", 32'(bus.result_valid), 32'd0);
    chk("single_gnt_after", 32'(bus.gnt), 32'd0);

    // Zero multiplier on requester 2.
    set_op(2, 8'd200, 8'd0);
    b_ldp = ldp_n; b_done = done_n;
    bus.req = 4'b0100;
    wait_rv("zero", 20, n);
    chk("zero_latency", 32'(n), 32'd4);
    chk("zero_result", 32'(bus.result), 32'd0);
    chk("zero_done", 32'(bus.done), 32'b0100);
    chk("zero_ldp", 32'(ldp_n - b_ldp), 32'd0);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("zero_done_count", 32'(done_n - b_done), 32'd1);

    // Maximum operands on requester 0 (pointer is at 3, search wraps).
    set_op(0, 8'd255, 8'd255);
    b_ldp = ldp_n;
    bus.req = 4'b0001;
    wait_rv("max", 300, n);
    chk("max_latency", 32'(n), 32'd259);
    chk("max_result", 32'(bus.result), 32'd65025);
    chk("max_ldp", 32'(ldp_n - b_ldp), 32'd255);
    chk("max_done", 32'(bus.done), 32'b0001);
    bus.req = 4'b0000;
    tick();

    // Fairness from a freshly reset pointer, every requester asking.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'd1);
    bus.req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      wait_rv("fair", 20, n);
      chk("fair_latency", 32'(n), 32'd5);
      chk("fair_done", 32'(bus.done), 32'd1 << exp_ord[j]);
      chk("fair_result", 32'(bus.result), 32'(exp_ord[j] + 1));
      if (j == 5) bus.req = 4'b0000;
      tick();
      chk("fair_idle_gap", 32'(busy), 32'd0);
    end

    // Withdrawal of req[1] during ACC; operands scrambled after LOAD_B.
    set_op(1, 8'd5, 8'd3);
    bus.req = 4'b0010;
    repeat (4) tick();
    chk("wd_in_acc", 32'(bus.ld_p), 32'd1);
    bus.req = 4'b0000;
    set_op(1, 8'd99, 8'd99);
    wait_rv("wd", 20, n2);
    chk("wd_latency", 32'(4 + n2), 32'd7);
    chk("wd_result", 32'(bus.result), 32'd15);
    chk("wd_done", 32'(bus.done), 32'b0010);
    tick();

    // Pointer now 2: with all requesting, requester 2 wins.
    for (int i = 0; i < NREQ; i++) set_op(i, 8'd7, 8'd0);
    bus.req = 4'b1111;
    wait_rv("ptr", 20, n);
    chk("ptr_done", 32'(bus.done), 32'b0100);
    bus.req = 4'b0000;
    tick();

    // Reset during ACC drops the job silently.
    set_op(0, 8'd3, 8'd4);
    bus.req = 4'b0001;
    repeat (4) tick();
    chk("rst_acc_in_acc", 32'(bus.ld_p), 32'd1);
    b_done = done_n;
    rst = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    chk("rst_acc_busy", 32'(busy), 32'd0);
    chk("rst_acc_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_acc_strobes", 32'({bus.ld_a, bus.ld_b, bus.ld_p, bus.dec, bus.clr}), 32'd0);
    chk("rst_acc_result", 32'(bus.result), 32'd0);
    chk("rst_acc_rv", 32'(bus.result_valid), 32'd0);
    repeat (3) tick();
    chk("rst_acc_no_done", 32'(done_n - b_done), 32'd0);
    set_op(3, 8'd2, 8'd2);
    bus.req = 4'b1000;
    wait_rv("post_rst", 20, n);
    chk("post_rst_latency", 32'(n), 32'd6);
    chk("post_rst_result", 32'(bus.result), 32'd4);
    chk("post_rst_done", 32'(bus.done), 32'b1000);
    bus.req = 4'b0000;
    tick();

    chk("total_done", 32'(done_n), 32'd12);
    chk("monitor", 32'(bad_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
